// File: rtl/sensor_pkg.sv
// Shared types and defaults for the doorway sensor conditioner.
package sensor_pkg;

  localparam int unsigned DEB_CYCLES_DEF   = 4;
  localparam int unsigned STUCK_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    ST_LOW   = 3'd0,
    ST_RISE  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_FALL  = 3'd3,
    ST_STUCK = 3'd4
  } chan_state_e;

endpackage

// File: rtl/sensor_chan.sv
// One sensor channel: 2-flop synchronizer, debounce FSM and stuck-beam detector.
module sensor_chan
  import sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic clr_fault,
  output logic out,
  output logic fault
);

  localparam int unsigned DCW = $clog2(DEB_CYCLES);
  localparam int unsigned SCW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [SCW-1:0] SCNT_LAST = SCW'(STUCK_CYCLES - 1);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  chan_state_e    state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           out_q, out_d;
  logic           fault_q, fault_d;
  logic           s;

  assign s = sync2_q;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    dcnt_d  = dcnt_q;
    scnt_d  = scnt_q;

    unique case (state_q)
      ST_LOW: begin
        dcnt_d = '0;
        scnt_d = '0;
        if (s) begin
          state_d = ST_RISE;
          dcnt_d  = DCW'(1);
        end
      end
      ST_RISE: begin
        if (!s) begin
          state_d = ST_LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_HIGH;
          dcnt_d  = '0;
          scnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      // Stuck timeout outranks any falling-edge activity in HIGH and FALL.
      ST_HIGH: begin
        if (scnt_q == SCNT_LAST) begin
          state_d = ST_STUCK;
          dcnt_d  = '0;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCW'(1);
          if (!s) begin
            state_d = ST_FALL;
            dcnt_d  = DCW'(1);
          end
        end
      end
      ST_FALL: begin
        if (scnt_q == SCNT_LAST) begin
          state_d = ST_STUCK;
          dcnt_d  = '0;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCW'(1);
          if (s) begin
            state_d = ST_HIGH;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d = ST_LOW;
            dcnt_d  = '0;
            scnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DCW'(1);
          end
        end
      end
      ST_STUCK: begin
        if (clr_fault && !s) begin
          state_d = ST_LOW;
          dcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOW;
        dcnt_d  = '0;
        scnt_d  = '0;
      end
    endcase

    out_d   = (state_d == ST_HIGH) || (state_d == ST_FALL);
    fault_d = (state_d == ST_STUCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LOW;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      out_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
      out_q   <= out_d;
      fault_q <= fault_d;
    end
  end

  assign out   = out_q;
  assign fault = fault_q;

endmodule

// File: rtl/sensor_debounce.sv
// Two independent debounced light-beam channels feeding the occupancy controller.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw1,
  input  logic       raw2,
  input  logic       clr_fault,
  output logic       x1,
  output logic       x2,
  output logic [1:0] fault
);

  logic fault1;
  logic fault2;

  sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan1 (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw1),
    .clr_fault(clr_fault),
    .out      (x1),
    .fault    (fault1)
  );

  sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan2 (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw2),
    .clr_fault(clr_fault),
    .out      (x2),
    .fault    (fault2)
  );

  assign fault = {fault2, fault1};

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed scenarios plus random bouncing inputs checked against a run-length model.
module tb_sensor_debounce;

  localparam int unsigned TB_DEB   = 4;
  localparam int unsigned TB_STUCK = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw1 = 1'b0;
  logic       raw2 = 1'b0;
  logic       clr_fault = 1'b0;
  logic       x1;
  logic       x2;
  logic [1:0] fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;

  sensor_debounce #(
    .DEB_CYCLES  (TB_DEB),
    .STUCK_CYCLES(TB_STUCK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw1     (raw1),
    .raw2     (raw2),
    .clr_fault(clr_fault),
    .x1       (x1),
    .x2       (x2),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: an output flips once the synchronized input has disagreed with it
  // for DEB consecutive samples; a beam seen high for STUCK edges latches a fault.
  bit          s1_m[2];
  bit          s2_m[2];
  bit          out_m[2];
  bit          flt_m[2];
  int unsigned run_m[2];
  int unsigned hi_m[2];

  always @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      bit s;
      bit r;
      r = (ch == 0) ? raw1 : raw2;
      s = s2_m[ch];
      if (rst) begin
        s1_m[ch] = 1'b0; s2_m[ch] = 1'b0; out_m[ch] = 1'b0;
        flt_m[ch] = 1'b0; run_m[ch] = 0; hi_m[ch] = 0;
      end else begin
        if (flt_m[ch]) begin
          if (clr_fault && !s) begin
            flt_m[ch] = 1'b0;
            run_m[ch] = 0;
          end
        end else begin
          run_m[ch] = (s != out_m[ch]) ? run_m[ch] + 1 : 0;
          if (out_m[ch]) hi_m[ch] = hi_m[ch] + 1;
          if (out_m[ch] && hi_m[ch] == TB_STUCK) begin
            out_m[ch] = 1'b0; flt_m[ch] = 1'b1; hi_m[ch] = 0; run_m[ch] = 0;
          end else if (run_m[ch] == TB_DEB) begin
            out_m[ch] = !out_m[ch]; run_m[ch] = 0; hi_m[ch] = 0;
          end
        end
        s2_m[ch] = s1_m[ch];
        s1_m[ch] = r;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_x1", x1, out_m[0]);
      check("model_x2", x2, out_m[1]);
      check("model_fault", fault, {flt_m[1], flt_m[0]});
    end
  end

  initial begin
    bit          pat[8];
    bit          lvl[2];
    int unsigned hold[2];

    pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    tick(2);
    chk_en = 1'b1;
    check("rst_x1", x1, 0);
    check("rst_x2", x2, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;

    // Clean rise: x1 asserts exactly five edges after capture
    raw1 = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick(1);
      check("rise_x1", x1, (k == 5) ? 1 : 0);
    end
    check("rise_x2", x2, 0);
    check("rise_fault", fault, 0);

    // Bounce on release keeps x1 high; stable low drops it five edges after capture
    for (int i = 0; i < 8; i++) begin
      raw1 = pat[i];
      tick(1);
      check("bounce_x1", x1, 1);
    end
    raw1 = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick(1);
      check("release_x1", x1, (k < 5) ? 1 : 0);
    end

    // Glitch of three samples is rejected, four samples is accepted
    raw2 = 1'b1;
    tick(3);
    raw2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_x2", x2, 0);
    end
    raw2 = 1'b1;
    tick(4);
    raw2 = 1'b0;
    tick(2);
    check("accept4_x2", x2, 1);
    tick(6);
    check("accept4_fall_x2", x2, 0);

    // Stuck beam: x1 drops and fault rises on the same edge
    raw1 = 1'b1;
    tick(25);
    check("prestuck_x1", x1, 1);
    check("prestuck_fault", fault, 0);
    tick(1);
    check("stuck_x1", x1, 0);
    check("stuck_fault", fault, 2'b01);
    check("stuck_x2", x2, 0);

    // Clear while beam still broken is ignored
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    tick(2);
    check("clr_ignored_fault", fault, 2'b01);
    check("clr_ignored_x1", x1, 0);

    // Clear after the synchronized level is low
    raw1 = 1'b0;
    tick(3);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check("clr_fault", fault, 0);

    // Reset in the middle of FALL, then a full rise is needed again
    raw1 = 1'b1;
    raw2 = 1'b1;
    tick(6);
    check("pre_fall_x1", x1, 1);
    check("pre_fall_x2", x2, 1);
    raw1 = 1'b0;
    raw2 = 1'b0;
    tick(3);
    check("in_fall_x1", x1, 1);
    rst  = 1'b1;
    raw1 = 1'b1;
    raw2 = 1'b1;
    tick(1);
    check("midrst_x1", x1, 0);
    check("midrst_x2", x2, 0);
    check("midrst_fault", fault, 0);
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick(1);
      check("rerise_x1", x1, (k == 5) ? 1 : 0);
    end

    // Random bouncing levels with occasional clears and resets
    lvl[0] = raw1;
    lvl[1] = raw2;
    hold   = '{0, 0};
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          lvl[ch]  = !lvl[ch];
          hold[ch] = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
        end
        hold[ch]--;
      end
      raw1      = lvl[0];
      raw2      = lvl[1];
      clr_fault = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst       = 1'b0;
    clr_fault = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
